// File: rtl/robot_pkg.sv
// Shared types and constants for the robot-side wall follower and the world model.
package robot_pkg;

  typedef enum logic [2:0] {
    SEARCH    = 3'd0,
    FOLLOW    = 3'd1,
    TURN_LEFT = 3'd2,
    STEP      = 3'd3,
    ROT_RIGHT = 3'd4,
    REMOVING  = 3'd5,
    STOPPED   = 3'd6
  } state_t;

  localparam logic [1:0] DIR_NORTH = 2'b00;
  localparam logic [1:0] DIR_SOUTH = 2'b01;
  localparam logic [1:0] DIR_EAST  = 2'b10;
  localparam logic [1:0] DIR_WEST  = 2'b11;

  localparam logic [2:0] CELL_FREE   = 3'd0;
  localparam logic [2:0] CELL_WALL   = 3'd1;
  localparam logic [2:0] CELL_TRASH  = 3'd2;
  localparam logic [2:0] CELL_TARGET = 3'd7;

endpackage

// File: rtl/wall_follower_ctrl.sv
// Left-hand wall follower with trash removal; halts on the target cell.
// Optional forward-step watchdog enabled by defining ROBOT_WATCHDOG_EN.
module wall_follower_ctrl
  import robot_pkg::*;
#(
  parameter int unsigned REMOVE_CYCLES    = 3,
  parameter int unsigned RIGHT_TURN_STEPS = 3,
  parameter int unsigned MAX_STEPS        = 400
) (
  input  logic clock,
  input  logic reset,
  input  logic head,
  input  logic left,
  input  logic under,
  input  logic barrier,
  output logic front,
  output logic turn,
  output logic remove
);

  localparam logic [1:0] RM_LAST  = 2'(REMOVE_CYCLES - 1);
  localparam logic [1:0] ROT_LAST = 2'(RIGHT_TURN_STEPS - 1);

  state_t     state_q, state_d;
  state_t     origin_q, origin_d;
  logic [1:0] rm_q, rm_d;
  logic [1:0] rot_q, rot_d;
  logic       front_d, turn_d, remove_d;

`ifdef ROBOT_WATCHDOG_EN
  localparam int unsigned SW = $clog2(MAX_STEPS + 1);
  localparam logic [SW-1:0] STEP_LIMIT = SW'(MAX_STEPS);
  logic [SW-1:0] steps_q, steps_d;
`endif

  always_comb begin
    state_d  = state_q;
    origin_d = origin_q;
    rm_d     = rm_q;
    rot_d    = rot_q;
    front_d  = 1'b0;
    turn_d   = 1'b0;
    remove_d = 1'b0;
    case (state_q)
      SEARCH, FOLLOW, STEP: begin
        if (under) begin
          state_d = STOPPED;
        end else if (barrier) begin
          state_d  = REMOVING;
          origin_d = (state_q == SEARCH) ? SEARCH : FOLLOW;
        end else if (state_q == SEARCH) begin
          if (left) begin
            state_d = FOLLOW;
          end else if (head) begin
            state_d  = ROT_RIGHT;
            origin_d = SEARCH;
          end else begin
            front_d = 1'b1;
          end
        end else if (state_q == FOLLOW) begin
          if (!left) begin
            state_d = TURN_LEFT;
          end else if (!head) begin
            front_d = 1'b1;
          end else begin
            state_d  = ROT_RIGHT;
            origin_d = FOLLOW;
          end
        end else begin
          front_d = !head;
          state_d = FOLLOW;
        end
      end
      TURN_LEFT: begin
        if (under) begin
          state_d = STOPPED;
        end else begin
          turn_d  = 1'b1;
          state_d = STEP;
        end
      end
      ROT_RIGHT: begin
        turn_d = 1'b1;
        if (rot_q == ROT_LAST) begin
          rot_d   = '0;
          state_d = origin_q;
        end else begin
          rot_d = rot_q + 2'd1;
        end
      end
      REMOVING: begin
        remove_d = 1'b1;
        if (rm_q == RM_LAST) begin
          rm_d    = '0;
          state_d = origin_q;
        end else begin
          rm_d = rm_q + 2'd1;
        end
      end
      STOPPED: begin
        state_d = STOPPED;
      end
      default: begin
        state_d = SEARCH;
      end
    endcase

`ifdef ROBOT_WATCHDOG_EN
    // The limiting front is still issued; only the following state is forced.
    steps_d = steps_q;
    if (front_d && steps_q != STEP_LIMIT) begin
      steps_d = steps_q + 1'b1;
      if (steps_d == STEP_LIMIT) state_d = STOPPED;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= SEARCH;
      origin_q <= SEARCH;
      rm_q     <= '0;
      rot_q    <= '0;
      front    <= 1'b0;
      turn     <= 1'b0;
      remove   <= 1'b0;
    end else begin
      state_q  <= state_d;
      origin_q <= origin_d;
      rm_q     <= rm_d;
      rot_q    <= rot_d;
      front    <= front_d;
      turn     <= turn_d;
      remove   <= remove_d;
    end
  end

`ifdef ROBOT_WATCHDOG_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) steps_q <= '0;
    else        steps_q <= steps_d;
  end
`endif

endmodule
